// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies the synchronised lock
// and drives the downstream system reset, all on the free-running reference clock.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned CNT_W               = 17,
    parameter int unsigned ERR_CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock_in,
    input  logic                 soft_reset_req,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 locked,
    output logic [1:0]           state,
    output logic [ERR_CNT_W-1:0] relock_cnt,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]     RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]     STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   locked_q, locked_d;
    logic [ERR_CNT_W-1:0]   relock_cnt_q, relock_cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    // Lock input synchroniser; only the last stage is ever consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_in};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        relock_cnt_d  = relock_cnt_q;
        timeout_err_d = timeout_err_q;
        if (soft_reset_req) begin
            // Soft restart wins over every other transition, including a loss in RUN.
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d       = ST_RESET_PLL;
                        cnt_d         = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                        if (relock_cnt_q != '1) begin
                            relock_cnt_d = relock_cnt_q + ERR_ONE;
                        end else begin
                            relock_cnt_d = relock_cnt_q;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs are decoded from the state being entered so they switch on that edge.
        pll_rst_d = (state_d == ST_RESET_PLL);
        sys_rst_d = (state_d != ST_RUN);
        locked_d  = (state_d == ST_RUN);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RESET_PLL;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            locked_q      <= 1'b0;
            relock_cnt_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            locked_q      <= locked_d;
            relock_cnt_q  <= relock_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign locked      = locked_q;
    assign state       = state_q;
    assign relock_cnt  = relock_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: randomized and directed lock
// patterns compared against a phase/age reference model of the supervisor rules.
module tb_pll_lock_supervisor;

    localparam int SYNC = 2;
    localparam int STAB = 8;
    localparam int TMO  = 32;
    localparam int PRST = 4;
    localparam logic [13:0] RESET_VEC = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock_in;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       locked;
    logic [1:0] state;
    logic [7:0] relock_cnt;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model: phase (0..3), cycles spent in phase, lock delay line.
    int m_phase;
    int m_age;
    int m_rc;
    bit m_terr;
    bit m_hist[$];

    pll_lock_supervisor #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(STAB), .LOCK_TIMEOUT_CYCLES(TMO),
        .PLL_RST_CYCLES(PRST), .CNT_W(17), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock_in(pll_lock_in), .soft_reset_req(soft_reset_req),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .locked(locked), .state(state),
        .relock_cnt(relock_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {state, pll_rst, sys_rst, locked, timeout_err, relock_cnt};
    endfunction

    function automatic logic [13:0] model_vec();
        return {2'(m_phase), (m_phase == 0), (m_phase != 3), (m_phase == 3), m_terr, 8'(m_rc)};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_age   = 0;
        m_rc    = 0;
        m_terr  = 1'b0;
        m_hist.delete();
        repeat (SYNC) m_hist.push_back(1'b0);
    endtask

    task automatic model_step();
        bit ls;
        ls = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(pll_lock_in);
        if (rst) begin
            model_reset();
        end else if (soft_reset_req) begin
            m_phase = 0; m_age = 0;
        end else begin
            case (m_phase)
                0: if (m_age == PRST - 1) begin m_phase = 1; m_age = 0; end else m_age++;
                1: if (ls) begin m_phase = 2; m_age = 0; end
                   else if (m_age == TMO - 1) begin m_phase = 0; m_age = 0; m_terr = 1'b1; end
                   else m_age++;
                2: if (!ls) begin m_phase = 1; m_age = 0; end
                   else if (m_age == STAB - 1) begin m_phase = 3; m_age = 0; end
                   else m_age++;
                default: if (!ls) begin m_phase = 1; m_age = 0; if (m_rc < 255) m_rc++; end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_lock_in = 1'b0; soft_reset_req = 1'b0;
        model_reset();
        #2;
        total++; if (dut_vec() !== RESET_VEC) begin bad++; $display("FAIL reset_hold got=%h exp=%h", dut_vec(), RESET_VEC); end
        repeat (2) begin
            tick();
            total++; if (dut_vec() !== RESET_VEC) begin bad++; $display("FAIL reset_clocked got=%h exp=%h", dut_vec(), RESET_VEC); end
        end
        rst = 1'b0;
    endtask

    task automatic test_release();
        int n;
        pll_lock_in = 1'b0;
        for (int k = 1; k <= PRST; k++) begin
            tick();
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL release_model got=%h exp=%h", dut_vec(), model_vec()); end
            total++; if (pll_rst !== 1'(k < PRST)) begin bad++; $display("FAIL pll_rst_pulse k=%0d got=%b", k, pll_rst); end
        end
        total++; if (state !== 2'd1) begin bad++; $display("FAIL enter_wait got=%0d exp=1", state); end
        pll_lock_in = 1'b1;
        n = 0;
        while (sys_rst !== 1'b0 && n < 60) begin
            tick(); n++;
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL release_model got=%h exp=%h", dut_vec(), model_vec()); end
        end
        total++; if (n != SYNC + 1 + STAB) begin bad++; $display("FAIL release_edge got=%0d exp=%0d", n, SYNC + 1 + STAB); end
        total++; if ({state, locked, timeout_err} !== {2'd3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL release_run state=%0d locked=%b terr=%b", state, locked, timeout_err);
        end
    endtask

    task automatic test_timeout();
        pll_lock_in = 1'b0;
        for (int k = 1; k <= 2 * (TMO + PRST) + PRST; k++) begin
            soft_reset_req = (k == 1);
            tick();
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL timeout_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec()); end
            total++; if (pll_rst !== 1'(((k - 1) % (TMO + PRST)) < PRST)) begin bad++; $display("FAIL timeout_pll_rst k=%0d got=%b", k, pll_rst); end
            total++; if (timeout_err !== 1'(k > TMO + PRST)) begin bad++; $display("FAIL timeout_err k=%0d got=%b", k, timeout_err); end
        end
        soft_reset_req = 1'b0;
    endtask

    task automatic test_stable_glitch();
        int n;
        int glen;
        n = 0;
        while (state !== 2'd1 && n < 20) begin
            tick(); n++;
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL glitch_model got=%h exp=%h", dut_vec(), model_vec()); end
        end
        for (int g = 0; g < 4; g++) begin
            glen = (g == 0) ? 5 : int'($urandom_range(1, STAB));
            pll_lock_in = 1'b1;
            repeat (glen) tick();
            pll_lock_in = 1'b0;
            repeat (SYNC + 4) begin
                tick();
                total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL glitch_model got=%h exp=%h", dut_vec(), model_vec()); end
                total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL glitch_no_release len=%0d got=%b", glen, sys_rst); end
            end
        end
        pll_lock_in = 1'b1;
        n = 0;
        while (state !== 2'd3 && n < 80) begin
            tick(); n++;
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL relock_model got=%h exp=%h", dut_vec(), model_vec()); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_run got=%b exp=1", locked); end
    endtask

    task automatic test_soft_same_cycle();
        int rc_exp;
        rc_exp = m_rc;
        pll_lock_in = 1'b0;
        repeat (SYNC) begin
            tick();
            total++; if (state !== 2'd3) begin bad++; $display("FAIL soft_pre_run got=%0d exp=3", state); end
        end
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        total++; if ({state, pll_rst, sys_rst, locked} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL soft_priority state=%0d pll_rst=%b sys_rst=%b", state, pll_rst, sys_rst);
        end
        total++; if (relock_cnt !== 8'(rc_exp)) begin bad++; $display("FAIL soft_relock got=%0d exp=%0d", relock_cnt, rc_exp); end
        total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL soft_model got=%h exp=%h", dut_vec(), model_vec()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (pll_lock_in) begin
                if ($urandom_range(0, 39) == 0) pll_lock_in = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                pll_lock_in = 1'b1;
            end
            soft_reset_req = ($urandom_range(0, 79) == 0);
            tick();
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
        end
        soft_reset_req = 1'b0;
    endtask

    task automatic test_loss_saturate();
        int n;
        int rc0;
        pll_lock_in = 1'b1;
        n = 0;
        while (state !== 2'd3 && n < 150) begin
            tick(); n++;
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL loss_model got=%h exp=%h", dut_vec(), model_vec()); end
        end
        rc0 = m_rc;
        pll_lock_in = 1'b0;
        n = 0;
        while (sys_rst !== 1'b1 && n < 10) begin tick(); n++; end
        total++; if (n != SYNC + 1) begin bad++; $display("FAIL loss_latency got=%0d exp=%0d", n, SYNC + 1); end
        total++; if (relock_cnt !== 8'((rc0 < 255) ? rc0 + 1 : 255)) begin bad++; $display("FAIL loss_count got=%0d base=%0d", relock_cnt, rc0); end
        for (int i = 0; i < 300; i++) begin
            pll_lock_in = 1'b1;
            n = 0;
            while (state !== 2'd3 && n < 40) begin
                tick(); n++;
                total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL sat_model got=%h exp=%h", dut_vec(), model_vec()); end
            end
            repeat ($urandom_range(0, 3)) tick();
            pll_lock_in = 1'b0;
            n = 0;
            while (state !== 2'd1 && n < 10) begin
                tick(); n++;
                total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL sat_model got=%h exp=%h", dut_vec(), model_vec()); end
            end
        end
        total++; if (relock_cnt !== 8'hFF) begin bad++; $display("FAIL relock_saturate got=%0d exp=255", relock_cnt); end
    endtask

    task automatic test_async_reset();
        int n;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        pll_lock_in = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 40) begin
            tick(); n++;
            total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL async_pre_model got=%h exp=%h", dut_vec(), model_vec()); end
        end
        total++; if (state !== 2'd2) begin bad++; $display("FAIL async_reach_stable got=%0d exp=2", state); end
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (dut_vec() !== RESET_VEC) begin bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), RESET_VEC); end
        tick();
        total++; if (dut_vec() !== RESET_VEC) begin bad++; $display("FAIL async_reset_hold got=%h exp=%h", dut_vec(), RESET_VEC); end
        rst = 1'b0;
        test_release();
    endtask

    initial begin
        test_reset();
        test_release();
        test_timeout();
        test_stable_glitch();
        test_soft_same_cycle();
        test_random();
        test_loss_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
